// File: rtl/pcie_ext_cap_walker.sv
// Walks the PCIe extended capability list from START_OFFSET, one config dword read per hop,
// and stops at the first header whose ID equals TARGET_CAP_ID.
module pcie_ext_cap_walker #(
  parameter logic [15:0] TARGET_CAP_ID = 16'h0019,
  parameter logic [11:0] START_OFFSET  = 12'h100,
  parameter int          MAX_HOPS      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        cfg_rd_req,
  output logic [11:0] cfg_rd_addr,
  input  logic        cfg_rd_ack,
  input  logic [31:0] cfg_rd_data,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] cap_offset,
  output logic [31:0] cap_header,
  output logic        walk_err
);

  localparam int HW = $clog2(MAX_HOPS + 1);
  localparam logic [HW-1:0] LAST_HOP = HW'(MAX_HOPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [11:0]   addr_r;
  logic [HW-1:0] hops_r;
  logic          found_r;
  logic          walk_err_r;
  logic [11:0]   cap_offset_r;
  logic [31:0]   cap_header_r;
  logic [11:0]   next_s;
  logic          term_s;
  logic          hit_s;
  logic          err_s;

  assign next_s = cfg_rd_data[31:20];

  // Classify the header being returned, in priority order.
  always_comb begin
    term_s = 1'b0;
    hit_s  = 1'b0;
    err_s  = 1'b0;
    if ((cfg_rd_data == 32'h0000_0000) || (cfg_rd_data == 32'hFFFF_FFFF)) begin
      term_s = 1'b1;
    end else if (cfg_rd_data[15:0] == TARGET_CAP_ID) begin
      term_s = 1'b1;
      hit_s  = 1'b1;
    end else if (next_s == 12'h000) begin
      term_s = 1'b1;
    end else if ((next_s < 12'h100) || (next_s[1:0] != 2'b00)) begin
      term_s = 1'b1;
      err_s  = 1'b1;
    end else if (hops_r == LAST_HOP) begin
      // Loop guard: this read was the MAX_HOPS-th one.
      term_s = 1'b1;
      err_s  = 1'b1;
    end else begin
      term_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = REQ;
        else       state_s = IDLE;
      end
      REQ: begin
        if (cfg_rd_ack && term_s) state_s = FIN;
        else                      state_s = REQ;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    cfg_rd_req = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_r)
      REQ: begin
        cfg_rd_req = 1'b1;
        busy       = 1'b1;
      end
      FIN:     done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  // Walk address, hop count and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r       <= 12'h000;
      hops_r       <= '0;
      found_r      <= 1'b0;
      walk_err_r   <= 1'b0;
      cap_offset_r <= 12'h000;
      cap_header_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            addr_r       <= START_OFFSET;
            hops_r       <= '0;
            found_r      <= 1'b0;
            walk_err_r   <= 1'b0;
            cap_offset_r <= 12'h000;
            cap_header_r <= 32'h0000_0000;
          end
        end
        REQ: begin
          if (cfg_rd_ack) begin
            if (hit_s) begin
              found_r      <= 1'b1;
              cap_offset_r <= addr_r;
              cap_header_r <= cfg_rd_data;
            end
            if (err_s) walk_err_r <= 1'b1;
            if (!term_s) begin
              addr_r <= next_s;
              hops_r <= hops_r + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_rd_addr = addr_r;
  assign found       = found_r;
  assign walk_err    = walk_err_r;
  assign cap_offset  = cap_offset_r;
  assign cap_header  = cap_header_r;

endmodule

// File: tb/tb_pcie_ext_cap_walker.sv
// Self-checking bench: a config-space responder with random ack delay, and a
// list-walking reference model evaluated straight from the config memory image.
module tb_pcie_ext_cap_walker;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cfg_rd_req;
  logic [11:0] cfg_rd_addr;
  logic        cfg_rd_ack;
  logic [31:0] cfg_rd_data;
  logic        busy, done, found, walk_err;
  logic [11:0] cap_offset;
  logic [31:0] cap_header;

  pcie_ext_cap_walker dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_rd_req(cfg_rd_req), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_ack(cfg_rd_ack), .cfg_rd_data(cfg_rd_data),
    .busy(busy), .done(done), .found(found),
    .cap_offset(cap_offset), .cap_header(cap_header), .walk_err(walk_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:1023];
  logic [11:0] rd_log [$];
  int          stab_err = 0;
  int          last_ack_cyc = 0;
  bit          resp_en = 1'b1;
  bit          inject = 1'b0;
  int          dly_max = 0;
  int          dly_fixed = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Config-space responder: holds off a random number of cycles, then acks one cycle.
  initial begin
    logic [11:0] a;
    int d;
    bit aborted;
    cfg_rd_ack  = 1'b0;
    cfg_rd_data = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk); #1;
      if (inject) begin
        cfg_rd_ack  = 1'b1;
        cfg_rd_data = 32'h0001_0019;
        @(posedge clk); #1;
        cfg_rd_ack  = 1'b0;
        cfg_rd_data = 32'hDEAD_BEEF;
        while (inject) begin @(posedge clk); #1; end
      end else if (resp_en && cfg_rd_req === 1'b1) begin
        a = cfg_rd_addr;
        d = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(dly_max, 0));
        aborted = 1'b0;
        for (int i = 0; i < d; i++) begin
          @(posedge clk); #1;
          if (!resp_en || cfg_rd_req !== 1'b1) begin aborted = 1'b1; break; end
          if (cfg_rd_addr !== a) stab_err++;
        end
        if (!aborted) begin
          cfg_rd_ack   = 1'b1;
          cfg_rd_data  = mem[a[11:2]];
          rd_log.push_back(a);
          last_ack_cyc = cyc;
          @(posedge clk); #1;
          cfg_rd_ack  = 1'b0;
          cfg_rd_data = 32'hDEAD_BEEF;
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic put(input int off, input logic [31:0] val);
    mem[off / 4] = val;
  endtask

  // Run one walk and check everything against the reference model.
  task automatic run_walk(input string name, input bit mid_start);
    logic [11:0] a, nx;
    logic [31:0] h;
    bit          e_found, e_err;
    logic [11:0] e_off;
    logic [31:0] e_hdr;
    logic [11:0] exp_addrs [$];
    int base, s0, k, n;
    bit got;
    a = 12'h100; e_found = 0; e_err = 0; e_off = 0; e_hdr = 0;
    for (int hop = 0; hop < 1000; hop++) begin
      h = mem[a / 4];
      exp_addrs.push_back(a);
      nx = 12'(h >> 20);
      if (h == 32'h0 || h == 32'hFFFF_FFFF) break;
      if ((h & 32'hFFFF) == 32'h0019) begin e_found = 1; e_off = a; e_hdr = h; break; end
      if (nx == 0) break;
      if (nx < 12'h100 || (nx % 4) != 0) begin e_err = 1; break; end
      if (hop + 1 == 64) begin e_err = 1; break; end
      a = nx;
    end

    base = rd_log.size();
    s0 = stab_err;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({name, " first_req"}, 32'(cfg_rd_req), 32'd1);
    chk({name, " first_addr"}, 32'(cfg_rd_addr), 32'h100);
    got = 1'b0;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      start = mid_start && (k == 5);
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    start = 1'b0;
    chk({name, " done_seen"}, 32'(got), 32'd1);
    chk({name, " done_latency"}, 32'(cyc), 32'(last_ack_cyc + 1));
    chk({name, " busy_at_done"}, 32'(busy), 32'd0);
    chk({name, " found"}, 32'(found), 32'(e_found));
    chk({name, " walk_err"}, 32'(walk_err), 32'(e_err));
    chk({name, " not_both"}, 32'(found & walk_err), 32'd0);
    chk({name, " cap_offset"}, 32'(cap_offset), 32'(e_off));
    chk({name, " cap_header"}, cap_header, e_hdr);
    chk({name, " reads"}, 32'(rd_log.size() - base), 32'(exp_addrs.size()));
    chk({name, " addr_stable"}, 32'(stab_err - s0), 32'd0);
    n = (rd_log.size() - base < exp_addrs.size()) ? rd_log.size() - base : exp_addrs.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s read_addr[%0d]", name, i), 32'(rd_log[base + i]), 32'(exp_addrs[i]));
    // A start arriving in the done cycle must be ignored.
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({name, " done_pulse"}, 32'(done), 32'd0);
    chk({name, " fin_start_ignored"}, 32'(busy | cfg_rd_req), 32'd0);
    chk({name, " result_hold"}, 32'(found), 32'(e_found));
  endtask

  task automatic setup_t1();
    clear_mem();
    put(12'h100, 32'h1400_0001);
    put(12'h140, 32'h0001_0019);
  endtask

  initial begin
    logic [11:0] offs [0:5];
    int nn, kind;
    logic [15:0] id;
    logic [11:0] nxt;
    rst = 1'b1;
    start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {cfg_rd_req, busy, done, found, walk_err, cap_offset, cap_header[14:0]}, 32'd0);
    chk("reset_header", cap_header, 32'd0);
    chk("reset_addr", 32'(cfg_rd_addr), 32'd0);
    rst = 1'b0;

    // T1 found
    setup_t1();
    dly_max = 2;
    run_walk("T1", 1'b0);
    chk("T1 const_offset", 32'(cap_offset), 32'h140);
    chk("T1 const_header", cap_header, 32'h0001_0019);

    // T2 not found
    clear_mem();
    put(12'h100, 32'h1801_000B);
    put(12'h180, 32'h0001_0001);
    run_walk("T2", 1'b0);

    // T3 empty / unimplemented
    clear_mem();
    run_walk("T3a", 1'b0);
    put(12'h100, 32'hFFFF_FFFF);
    run_walk("T3b", 1'b0);

    // T4 self-loop, start pulse mid-walk must be ignored
    clear_mem();
    put(12'h100, 32'h1001_0002);
    dly_max = 1;
    run_walk("T4", 1'b1);

    // T5 malformed next pointers
    clear_mem();
    put(12'h100, 32'h0FC1_0001);
    run_walk("T5a", 1'b0);
    put(12'h100, 32'h1421_0001);
    run_walk("T5b", 1'b0);

    // Randomized lists with up to 7 cycles of ack delay
    dly_max = 7;
    for (int t = 0; t < 8; t++) begin
      clear_mem();
      nn = int'($urandom_range(5, 1));
      offs[0] = 12'h100;
      for (int i = 1; i < nn; i++) offs[i] = {10'($urandom_range(10'h3FF, 10'h041)), 2'b00};
      for (int i = 0; i < nn; i++) begin
        id = ($urandom_range(3, 0) == 0) ? 16'h0019 : 16'($urandom_range(16'hFFFF, 0));
        if (i < nn - 1) begin
          nxt = offs[i + 1];
        end else begin
          kind = int'($urandom_range(3, 0));
          nxt = (kind == 0) ? 12'h000 : (kind == 1) ? 12'h0F0 : (kind == 2) ? 12'h142 : 12'h100;
        end
        put(offs[i], {nxt, 4'($urandom_range(15, 0)), id});
      end
      if ($urandom_range(7, 0) == 0) put(offs[nn - 1], 32'h0);
      run_walk($sformatf("RND%0d", t), 1'b0);
    end

    // T6 reset in the middle of REQ, then a stray ack while idle
    setup_t1();
    dly_fixed = 7;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("T6 req_before_rst", 32'(cfg_rd_req), 32'd1);
    @(negedge clk); resp_en = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("T6 rst_req", 32'(cfg_rd_req), 32'd0);
    chk("T6 rst_status", 32'({busy, done, found, walk_err}), 32'd0);
    chk("T6 rst_results", 32'(cap_offset) | cap_header | 32'(cfg_rd_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk); inject = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("T6 stray_ack_ignored", 32'({busy, done, found, walk_err, cfg_rd_req}), 32'd0);
    @(negedge clk); inject = 1'b0;
    repeat (2) @(posedge clk);
    dly_fixed = -1;
    resp_en = 1'b1;
    dly_max = 7;
    run_walk("T6_T1", 1'b0);
    chk("T6 const_offset", 32'(cap_offset), 32'h140);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
